// File: rtl/message_serializer_pkg.sv
// Shared definitions for the message serializer block.
//   ser_state_t : serializer FSM encoding (IDLE, SHIFT, GAP)
//   MSG_*       : default word, gap-counter and frame-counter widths
package msg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_t;

   localparam int MSG_WIDTH = 8;
   localparam int MSG_GAP_W = 4;
   localparam int MSG_CNT_W = 8;

endpackage

// File: rtl/message_serializer_if.sv
// Load/serial-out bundle between a message producer and the serializer.
//   load        : producer request to send data_word
//   data_word   : WIDTH-bit message, MSB sent first
//   gap_cycles  : idle cycles to insert after the frame
//   ready       : serializer idle, next load is accepted
//   data_out    : serial bit stream (0 whenever bit_valid is low)
//   bit_valid   : data_out carries a message bit
//   frame_done  : one-cycle pulse alongside the last bit of a frame
//   frames_sent : completed-frame counter, wraps modulo 2**CNT_W
// master = producer side, slave = serializer side.
interface message_serializer_if
   import msg_pkg::*;
#(
   parameter int WIDTH = MSG_WIDTH,
   parameter int GAP_W = MSG_GAP_W,
   parameter int CNT_W = MSG_CNT_W
) ();

   logic             load;
   logic [WIDTH-1:0] data_word;
   logic [GAP_W-1:0] gap_cycles;
   logic             ready;
   logic             data_out;
   logic             bit_valid;
   logic             frame_done;
   logic [CNT_W-1:0] frames_sent;

   modport master (
      output load, data_word, gap_cycles,
      input  ready, data_out, bit_valid, frame_done, frames_sent
   );

   modport slave (
      input  load, data_word, gap_cycles,
      output ready, data_out, bit_valid, frame_done, frames_sent
   );

endinterface

// File: rtl/message_serializer.sv
// Parallel-to-serial message source. A word accepted on load (while ready)
// is shifted out MSB-first, one bit per clk, starting on the cycle after the
// load edge. After the last bit the output is held at 0 for the captured
// number of gap cycles before the next load can be accepted.
// Ports:
//   clk   : single clock, all logic on posedge
//   reset : synchronous, active-high; aborts any frame or gap in progress
//   bus   : message_serializer_if.slave (load/data_word/gap_cycles in;
//           ready/data_out/bit_valid/frame_done/frames_sent out)
// All outputs come straight from registers.
module message_serializer
   import msg_pkg::*;
#(
   parameter int WIDTH = MSG_WIDTH,
   parameter int GAP_W = MSG_GAP_W,
   parameter int CNT_W = MSG_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   message_serializer_if.slave  bus
);

   localparam int IDX_W = $clog2(WIDTH);

   ser_state_t       state_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [GAP_W-1:0] gap_reg;
   logic [CNT_W-1:0] frames_reg;
   logic             data_out_reg;
   logic             bit_valid_reg;
   logic             frame_done_reg;
   logic             ready_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         shift_reg      <= '0;
         idx_reg        <= '0;
         gap_reg        <= '0;
         frames_reg     <= '0;
         data_out_reg   <= 1'b0;
         bit_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         ready_reg      <= 1'b1;
      end else begin
         frame_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               data_out_reg  <= 1'b0;
               bit_valid_reg <= 1'b0;
               if (bus.load) begin
                  // Snapshot word and gap so later input changes cannot
                  // disturb the frame in flight.
                  shift_reg <= bus.data_word;
                  gap_reg   <= bus.gap_cycles;
                  idx_reg   <= IDX_W'(WIDTH - 1);
                  state_reg <= SHIFT;
                  ready_reg <= 1'b0;
               end
            end

            SHIFT: begin
               data_out_reg  <= shift_reg[WIDTH-1];
               bit_valid_reg <= 1'b1;
               shift_reg     <= {shift_reg[WIDTH-2:0], 1'b0};
               idx_reg       <= idx_reg - 1'b1;
               if (idx_reg == '0) begin
                  // Last bit goes out on this edge.
                  frame_done_reg <= 1'b1;
                  frames_reg     <= frames_reg + 1'b1;
                  if (gap_reg == '0) begin
                     state_reg <= IDLE;
                     ready_reg <= 1'b1;
                  end else begin
                     state_reg <= GAP;
                  end
               end
            end

            GAP: begin
               data_out_reg  <= 1'b0;
               bit_valid_reg <= 1'b0;
               gap_reg       <= gap_reg - 1'b1;
               // gap_reg is nonzero on entry, so this leaves after exactly
               // the captured number of idle cycles.
               if (gap_reg == GAP_W'(1)) begin
                  state_reg <= IDLE;
                  ready_reg <= 1'b1;
               end
            end

            default: begin
               state_reg     <= IDLE;
               data_out_reg  <= 1'b0;
               bit_valid_reg <= 1'b0;
               ready_reg     <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready       = ready_reg;
   assign bus.data_out    = data_out_reg;
   assign bus.bit_valid   = bit_valid_reg;
   assign bus.frame_done  = frame_done_reg;
   assign bus.frames_sent = frames_reg;

endmodule

// File: tb/tb_message_serializer.sv
// Self-checking bench for message_serializer. The driver issues loads
// (directed cases then random), a timing model of the producer side decides
// which loads are accepted, and every accepted word is expanded into its
// expected serial bits (value, edge number, last-bit flag, frame count) on a
// scoreboard queue. A monitor on the falling edge pops and compares whenever
// bit_valid is high, and checks that idle cycles are quiet.
module tb_message_serializer;

   localparam int WIDTH = 8;
   localparam int GAP_W = 4;
   localparam int CNT_W = 3;

   typedef struct {
      bit b;
      bit last;
      int cnt;
      int at;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   next_ok = 0;
   int   model_cnt = 0;
   bit   rst_seen = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   message_serializer_if #(.WIDTH(WIDTH), .GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();

   message_serializer #(.WIDTH(WIDTH), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, cyc);
      end
   endtask

   // One clock of stimulus. The acceptance model: a load sampled on edge t
   // is taken when t >= next_ok; it occupies WIDTH bit edges, then the gap,
   // then ready returns, so the earliest following accept is t+WIDTH+gap+1.
   task automatic step(input bit rs, input bit ld, input logic [WIDTH-1:0] w,
                       input logic [GAP_W-1:0] g, output bit acc);
      int t;
      reset          = rs;
      bus.load       = ld;
      bus.data_word  = w;
      bus.gap_cycles = g;
      t = cyc + 1;
      if (rst_seen) check("ready", 32'(bus.ready), 32'(t >= next_ok));
      acc = ld && !rs && (t >= next_ok);
      if (acc) begin
         for (int i = 0; i < WIDTH; i++) begin
            exp_t e;
            e.b    = w[WIDTH-1-i];
            e.at   = t + 1 + i;
            e.last = (i == WIDTH - 1);
            e.cnt  = (model_cnt + 1) % (1 << CNT_W);
            q.push_back(e);
         end
         model_cnt = (model_cnt + 1) % (1 << CNT_W);
         next_ok   = t + WIDTH + int'(g) + 1;
         $display("load accepted: word=%02h gap=%0d edge=%0d frame#=%0d", w, g, t, model_cnt);
      end
      @(posedge clk);
      #1;
      if (rs) begin
         q.delete();
         model_cnt = 0;
         next_ok   = t + 1;
         rst_seen  = 1;
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, acc);
   endtask

   task automatic reset_checks();
      check("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
      check("rst_data_out", 32'(bus.data_out), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
      check("rst_frames_sent", 32'(bus.frames_sent), 32'd0);
      check("rst_ready", 32'(bus.ready), 32'd1);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst_seen) begin
         if (bus.bit_valid === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bit: got data_out=%b expected no bit at edge %0d", bus.data_out, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("bit_time", 32'(cyc), 32'(e.at));
               check("bit_value", 32'(bus.data_out), 32'(e.b));
               check("frame_done", 32'(bus.frame_done), 32'(e.last));
               if (e.last) check("frames_sent", 32'(bus.frames_sent), 32'(e.cnt));
            end
         end else begin
            check("idle_bit_valid", 32'(bus.bit_valid), 32'd0);
            check("idle_data_out", 32'(bus.data_out), 32'd0);
            check("idle_frame_done", 32'(bus.frame_done), 32'd0);
            if (q.size() > 0 && q[0].at <= cyc) begin
               exp_t e;
               e = q.pop_front();
               checks++;
               errors++;
               $display("FAIL missing_bit: got no bit expected %b at edge %0d", e.b, e.at);
            end
         end
      end
   end

   initial begin
      bit acc;
      reset          = 1'b1;
      bus.load       = 1'b0;
      bus.data_word  = '0;
      bus.gap_cycles = '0;

      // Reset held three cycles, with a load attempt that must be dropped.
      step(1'b1, 1'b0, '0, '0, acc);
      step(1'b1, 1'b1, 8'hC3, 4'd2, acc);
      step(1'b1, 1'b0, '0, '0, acc);
      reset_checks();

      // B4, no gap.
      step(1'b0, 1'b1, 8'hB4, 4'd0, acc);
      idle(10);

      // F0 with gap 3, then 0F offered continuously until accepted.
      step(1'b0, 1'b1, 8'hF0, 4'd3, acc);
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b1, 8'h0F, 4'd0, acc);
         if (acc) break;
      end
      idle(10);

      // Loads pulsed while busy are ignored; input changes after capture
      // do not affect the frame in flight.
      step(1'b0, 1'b1, 8'h5A, 4'd2, acc);
      step(1'b0, 1'b0, 8'hFF, 4'd7, acc);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h11 * (i + 1)), 4'(i), acc);
      idle(12);

      // Reset in the middle of FF, together with a load that reset beats.
      step(1'b0, 1'b1, 8'hFF, 4'd0, acc);
      idle(3);
      step(1'b1, 1'b1, 8'hAA, 4'd5, acc);
      reset_checks();
      step(1'b0, 1'b1, 8'h3C, 4'd1, acc);
      idle(12);

      // load held high: 01 frames with gap 1, counter wraps past 2**CNT_W-1.
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 8'h01, 4'd1, acc);
      idle(4);

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         bit rs;
         bit ld;
         logic [WIDTH-1:0] w;
         logic [GAP_W-1:0] g;
         rs = ($urandom_range(0, 199) == 0);
         ld = ($urandom_range(0, 2) != 0);
         w  = WIDTH'($urandom);
         g  = ($urandom_range(0, 3) == 0) ? GAP_W'($urandom) : GAP_W'($urandom_range(0, 2));
         step(rs, ld, w, g, acc);
      end

      idle(40);
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
